// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- single pipeline stage register with valid/ready handshake.
//
// Holds one entry (payload + control) between two pipeline stages. Supports
// stall (freeze), flush (bubble insertion) and a saturating stall counter.
// Optional second "skid" slot, enabled by defining PIPE_STAGE_SKID_EN, breaks
// the combinational out_ready -> in_ready path.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   stall, flush         freeze stage / kill all held entries
//   in_valid/in_ready    upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready  downstream handshake, out_data/out_ctrl payload
//   occupancy            number of held entries (0..1, or 0..2 with skid)
//   stall_cnt            saturating count of stalled cycles
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [15:0]       r_stall_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_issue;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Ready depends only on local state: a free skid slot can always absorb
    // one entry even if downstream does not take the main entry this cycle.
    assign w_in_ready = rst_n & ~stall & ~flush & ~r_skid_valid;
    assign occupancy  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
`else
    assign w_in_ready = rst_n & ~stall & ~flush & (~r_main_valid | out_ready);
    assign occupancy  = {1'b0, r_main_valid};
`endif

    // Stall hides the held entry from downstream without disturbing it.
    assign out_valid = r_main_valid & ~stall;
    assign in_ready  = w_in_ready;
    assign w_accept  = in_valid & w_in_ready;
    // Flush wins over a downstream handshake: the entry is killed, not issued.
    assign w_issue   = out_valid & out_ready & ~flush;

    assign out_data  = r_main_data;
    // Control is masked while stalled so an invisible entry never shows
    // non-zero control; the register itself keeps its value.
    assign out_ctrl  = out_valid ? r_main_ctrl : {CTRL_W{1'b0}};
    assign stall_cnt = r_stall_cnt;

    // Main slot: the entry currently presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= {DATA_W{1'b0}};
            r_main_ctrl  <= {CTRL_W{1'b0}};
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= {CTRL_W{1'b0}};
        end else if (!stall) begin
`ifdef PIPE_STAGE_SKID_EN
            // An older entry in skid always has priority for the main slot;
            // accept is impossible then because in_ready is low.
            if (w_issue && r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_ctrl  <= r_skid_ctrl;
            end else if (w_accept && (!r_main_valid || w_issue)) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end else if (w_issue) begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= {CTRL_W{1'b0}};
            end
`else
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end else if (w_issue) begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= {CTRL_W{1'b0}};
            end
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid slot: catches an entry accepted while main is occupied and stuck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= {DATA_W{1'b0}};
            r_skid_ctrl  <= {CTRL_W{1'b0}};
        end else if (flush) begin
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= {CTRL_W{1'b0}};
        end else if (!stall) begin
            if (w_issue && r_skid_valid) begin
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= {CTRL_W{1'b0}};
            end else if (w_accept && r_main_valid && !w_issue) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_skid_ctrl  <= in_ctrl;
            end
        end
    end
`endif

    // Saturating stall counter; counts even while flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, an in-order
// streaming sequence with a toggling out_ready, skid fill/drain (skid build
// only), stall counter saturation and reset in mid-stall.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic P_SKID = 1'b1;
`else
    localparam logic P_SKID = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        iv;
        logic [15:0] id;
        logic [7:0]  ic;
        logic        ordy;
        logic        e_ov;
        logic [15:0] e_od;
        logic [7:0]  e_oc;
        logic [1:0]  e_occ;
        logic        e_ir;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        int sent;
        int got;
        logic ordy_t;

        // Inputs deliberately active during reset: outputs must stay quiet.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 16'h9999; in_ctrl = 8'h99; out_ready = 1'b1;
        #3;
        chk("rst_ov",  {31'd0, out_valid}, 32'd0);
        chk("rst_od",  {16'd0, out_data},  32'd0);
        chk("rst_oc",  {24'd0, out_ctrl},  32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_ir",  {31'd0, in_ready},  32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);

        //         st    fl    iv    id       ic     ordy  ov    od       oc     occ   ir      cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 8'h05, 1'b1, 1'b1, 16'h1234, 8'h05, 2'd1, 1'b1,   16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h5678, 8'h0A, 1'b1, 1'b1, 16'h5678, 8'h0A, 2'd1, 1'b1,   16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h5678, 8'h00, 2'd0, 1'b1,   16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 8'h11, 1'b1, 1'b1, 16'hAAAA, 8'h11, 2'd1, 1'b1,   16'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 8'h22, 1'b1, 1'b0, 16'hAAAA, 8'h00, 2'd1, 1'b0,   16'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 8'h22, 1'b1, 1'b0, 16'hAAAA, 8'h00, 2'd1, 1'b0,   16'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 8'h22, 1'b1, 1'b0, 16'hAAAA, 8'h00, 2'd1, 1'b0,   16'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hAAAA, 8'h11, 2'd1, P_SKID, 16'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'hCCCC, 8'h33, 1'b0, 1'b0, 16'hAAAA, 8'h00, 2'd0, 1'b0,   16'd3};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'hCCCC, 8'h33, 1'b0, 1'b0, 16'hAAAA, 8'h00, 2'd0, 1'b0,   16'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'hDDDD, 8'h44, 1'b0, 1'b1, 16'hDDDD, 8'h44, 2'd1, P_SKID, 16'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'hEEEE, 8'h55, 1'b1, 1'b0, 16'hDDDD, 8'h00, 2'd0, 1'b0,   16'd4};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hDDDD, 8'h00, 2'd0, 1'b1,   16'd4};

        @(negedge clk);
        rst_n = 1'b1;

        // Each vector: drive, clock once, check with the inputs still applied.
        for (int i = 0; i < 13; i++) begin
            stall = vecs[i].st; flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].id; in_ctrl = vecs[i].ic; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ov", i),  {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_od", i),  {16'd0, out_data},  {16'd0, vecs[i].e_od});
            chk($sformatf("v%0d_oc", i),  {24'd0, out_ctrl},  {24'd0, vecs[i].e_oc});
            chk($sformatf("v%0d_occ", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
            chk($sformatf("v%0d_ir", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].e_cnt});
        end

        // Stream 0001..0008 with out_ready toggling; outputs must arrive in order.
        sent = 0; got = 0; ordy_t = 1'b0;
        stall = 1'b0; flush = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_data   = 16'(sent + 1);
            in_ctrl   = 8'(sent + 1);
            out_ready = ordy_t;
            ordy_t    = ~ordy_t;
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("stream_order", {16'd0, out_data}, 32'(got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(got), 32'd8);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_empty", {30'd0, occupancy}, 32'd0);

`ifdef PIPE_STAGE_SKID_EN
        // Fill main and skid with downstream blocked, then drain in order.
        in_valid = 1'b1; in_data = 16'hC001; in_ctrl = 8'hC1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_data = 16'hC002; in_ctrl = 8'hC2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        chk("skid_occ2", {30'd0, occupancy}, 32'd2);
        chk("skid_ir0",  {31'd0, in_ready},  32'd0);
        chk("skid_od1",  {16'd0, out_data},  32'h0000C001);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("skid_od2",  {16'd0, out_data},  32'h0000C002);
        chk("skid_oc2",  {24'd0, out_ctrl},  32'h000000C2);
        chk("skid_occ1", {30'd0, occupancy}, 32'd1);
        @(posedge clk);
        #1;
        chk("skid_occ0", {30'd0, occupancy}, 32'd0);
        out_ready = 1'b0;
`endif

        // Load one entry, then stall long enough to saturate the counter.
        in_valid = 1'b1; in_data = 16'hF00D; in_ctrl = 8'h0F; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stall = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("sat_ov",  {31'd0, out_valid}, 32'd0);
        chk("sat_occ", {30'd0, occupancy}, 32'd1);
        @(posedge clk);
        #1;
        chk("sat_nowrap", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Reset pulse in the middle of the stall.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_occ", {30'd0, occupancy}, 32'd0);
        chk("mid_rst_od",  {16'd0, out_data},  32'd0);
        chk("mid_rst_ir",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; in_ctrl = 8'h01; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
        chk("post_rst_od", {16'd0, out_data},  32'h00001111);
        chk("post_rst_oc", {24'd0, out_ctrl},  32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 16, width of the datapath payload (ALU result, store data, flags).
REQ-002 Parameter CTRL_W, 8, width of the control payload (write enables, selects, dst addr); zeroed whenever a slot is empty.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  freeze stage: no accept, no issue, contents held.
REQ-006 flush  input  1  synchronous kill of all held entries (bubble insertion).
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control.
REQ-011 out_valid  output  1  entry presented downstream.
REQ-012 out_ready  input  1  downstream accepts entry.
REQ-013 out_data  output  DATA_W  presented payload.
REQ-014 out_ctrl  output  CTRL_W  presented control; 0 when out_valid=0.
REQ-015 occupancy  output  2  held entry count, 0..2.
REQ-016 stall_cnt  output  16  saturating count of cycles with stall=1.

Function
REQ-017 Accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-018 Latency: entry accepted at edge N appears on out_* immediately after edge N (one cycle) when the stage was empty or drained at N.
REQ-019 Entries issue in acceptance order; no entry duplicated or lost except by flush.
REQ-020 stall=1: in_ready=0, out_valid=0 (gated), all entries, data and ctrl held unchanged.
REQ-021 flush=1: in_ready=0; at next edge all entries invalid, ctrl registers cleared to 0, data registers unchanged; flush overrides stall, accept and issue.
REQ-022 Main slot empties on issue without same-cycle refill; its ctrl register clears to 0 at that edge.
REQ-023 Issue and accept in the same cycle: main slot reloads with the new entry, out_valid stays 1.
REQ-024 Without skid (see REQ-031): in_ready = ~stall & ~flush & (~main_valid | out_ready); occupancy in 0..1.
REQ-025 stall_cnt increments by 1 on each edge with stall=1; holds at 16'hFFFF; counts regardless of flush.
REQ-026 out_data/out_ctrl driven directly from registers; no combinational path from in_* to out_*.

Reset
REQ-027 rst_n=0 asynchronously clears: main and skid valid, all data registers to 0, all ctrl registers to 0, stall_cnt to 0.
REQ-028 During reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0.
REQ-029 Reset asserted mid-transfer discards all entries; first accept permitted on first edge after rst_n rises.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN selects the skid buffer.
REQ-031 Defined: second (skid) slot added; in_ready = ~stall & ~flush & ~skid_valid, with no combinational dependence on out_ready; entry accepted while main valid and not issuing goes to skid; when main issues, skid moves to main at same edge (new accept then goes to skid or main per order); occupancy 0..2.
REQ-032 Undefined: no skid registers synthesised; behaviour per REQ-024; occupancy[1]=0 always.

Verification
REQ-033 Reset, then in_valid=1, in_data=16'h1234, in_ctrl=8'h05, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_ctrl=8'h05.
REQ-034 Stage full with 16'hAAAA, stall=1 for 3 cycles, in_valid=1 with 16'hBBBB -> in_ready=0, out_valid=0, stall_cnt=3, after stall drops out_data=16'hAAAA.
REQ-035 Stage full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=8'h00, occupancy=0, input not accepted.
REQ-036 Stream 16'h0001..16'h0008 with out_ready toggling every cycle -> output sequence exactly 0001..0008, no gaps in order.
REQ-037 PIPE_STAGE_SKID_EN defined: out_ready=0, send 16'hC001, 16'hC002 -> occupancy=2, in_ready=0; out_ready=1 -> C001 then C002 issued.
REQ-038 stall held 65540 cycles -> stall_cnt=16'hFFFF, no wrap; rst_n pulse mid-stall -> stall_cnt=0, occupancy=0.
